i2c_mem_slave: RTL and testbench
================================

Name: i2c_mem_slave

Overview:
Memory-side target of the I2C master. It sits directly downstream of the master on the shared bus and deserialises the 7-bit word address, the R/W bit and the data byte. It drives ack_n back to the master, writes to or reads from an internal byte array, and serialises read data back on SDA_IN. All logic runs on the master's system clock; SCL and SDA_OUT are sampled as ordinary synchronous inputs.

Parameters:
DATA_WIDTH, 8, bits per memory word and per data phase.
ADDR_WIDTH, 7, bits of word address carried in the address phase.
MEM_DEPTH, 128, number of implemented words; must be at most 2**ADDR_WIDTH.

Ports:
clk  in  1  system clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
SCL  in  1  serial clock from the master.
SDA_OUT  in  1  serial data from the master.
SDA_IN  out  1  serial read data to the master; 1 = released.
ack_n  out  1  active-low acknowledge to the master.
busy  out  1  high from START detection until STOP/abort returns the FSM to IDLE.
wr_done  out  1  one-clk pulse when a word is committed to memory.
rd_done  out  1  one-clk pulse when the last bit of a read word has been shifted out.

Behaviour:
- Reset values: ack_n=1, SDA_IN=1, busy=0, wr_done=0, rd_done=0, FSM=IDLE, bit counter=0. Memory contents are not reset.
- Edge detection: SCL and SDA_OUT are registered once (scl_q, sda_q).
  - rise: scl_q=0 and SCL=1.
  - fall: scl_q=1 and SCL=0.
  - START: SCL=1, scl_q=1, sda_q=1, SDA_OUT=0.
  - STOP: same SCL condition with SDA 0->1.
- Bit order: data is sampled on rise, MSB first.
- START is accepted in every state, including mid-byte (repeated start). It clears the counter and goes to ADDR.
- STOP in any state -> IDLE. A partial byte is discarded with no memory write and no pulse.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits, then R_W; 1 = write, 0 = read). After the 8th rise -> ADDR_ACK.
  - ADDR_ACK: on the next fall, drive ack_n=0 if address < MEM_DEPTH, else keep ack_n=1 and go to WAIT_STOP. ack_n is held through the 9th SCL high and released on the 9th fall. Then go to WR_DATA (R_W=1) or RD_DATA (R_W=0).
  - WR_DATA: shift 8 bits. After the 8th rise, write mem[addr] and pulse wr_done the following clk, then -> WR_ACK.
  - WR_ACK: ack_n=0 for the 9th SCL period (same timing as ADDR_ACK), then -> WAIT_STOP.
  - RD_DATA: on ADDR_ACK release, load the shift register from mem[addr] and drive its MSB on SDA_IN. Shift on each fall. After the 8th fall, set SDA_IN=1, pulse rd_done, and go to RD_ACK.
  - RD_ACK: sample SDA_OUT at the 9th rise (0 = master ACK, 1 = NACK), then -> WAIT_STOP.
  - WAIT_STOP: SDA_IN=1, ack_n=1; ignore all bits until START/STOP.
- Simultaneous events:
  - Reset overrides everything.
  - START/STOP override bit sampling in the same clk.
- Reset mid-operation: outputs return to reset values immediately. No memory write occurs for an in-flight byte.

Optional Feature:
Macro: I2C_SLAVE_AUTO_INC_EN.
- Defined:
  - After WR_ACK, return to WR_DATA with addr+1 for the next byte.
  - After RD_ACK with master ACK, return to RD_DATA with addr+1. NACK -> WAIT_STOP.
  - Address wraps from MEM_DEPTH-1 to 0.
- Undefined: exactly one data word per transaction, as listed above. Extra data bits are ignored in WAIT_STOP and ack_n stays 1.

Test Plan:
- Write: START, address 0x03, R_W=1, data 0x02, STOP -> ack_n=0 in the 9th slot of both bytes; wr_done pulses once; a following read of 0x03 returns 0x02.
- Read: preload mem[0x03]=0xA5; START, address 0x03, R_W=0 -> SDA_IN serialises 1,0,1,0,0,1,0,1 on successive falls; rd_done pulses once; SDA_IN=1 afterwards.
- Out of range with MEM_DEPTH=100: address 0x70, write -> ack_n stays 1; no wr_done; memory unchanged; busy drops on STOP.
- Abort: STOP after 4 data bits of write 0xFF to address 0x10 -> no wr_done; mem[0x10] keeps its old value; FSM in IDLE. Repeat with a repeated START -> new address phase accepted.
- Reset: assert reset_n=0 during the 5th address bit -> ack_n=1, SDA_IN=1, busy=0 within the same cycle; the next full transaction completes normally.
- AUTO_INC_EN: write burst at address 0x7F with bytes 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22; two wr_done pulses; without the macro only 0x7F is written.

Source files
------------

// File: rtl/i2c_mem_slave.sv
// -----------------------------------------------------------------------------
// i2c_mem_slave
//
// Memory-side target of the I2C master. It deserialises a word address plus
// R/W bit and one data word from SCL/SDA_OUT, acknowledges on ack_n, writes to
// or reads from an internal byte array, and serialises read data on SDA_IN.
// SCL and SDA_OUT are treated as ordinary synchronous inputs on clk.
//
// Optional feature (compile-time macro I2C_SLAVE_AUTO_INC_EN):
//   defined   : after each data ACK the address increments (wrapping from
//               MEM_DEPTH-1 to 0) and the next word is written / read.
//   undefined : exactly one data word per transaction.
//
// Parameters:
//   DATA_WIDTH  bits per memory word and per data phase
//   ADDR_WIDTH  bits of word address in the address phase
//   MEM_DEPTH   implemented words (<= 2**ADDR_WIDTH)
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   SCL       serial clock from the master
//   SDA_OUT   serial data from the master
//   SDA_IN    serial read data to the master (1 = released)
//   ack_n     active-low acknowledge to the master
//   busy      high while the FSM is outside IDLE
//   wr_done   one-clk pulse when a word is committed to memory
//   rd_done   one-clk pulse after the last bit of a read word
// -----------------------------------------------------------------------------
module i2c_mem_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_DEPTH  = 128
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SCL,
    input  logic SDA_OUT,
    output logic SDA_IN,
    output logic ack_n,
    output logic busy,
    output logic wr_done,
    output logic rd_done
);

    localparam int SH_W  = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 2);
    // Counter value at the last bit of each frame (address frame carries R/W too).
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [31:0]      DEPTH_U   = MEM_DEPTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_WAIT_STOP
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [SH_W-1:0]         shift_reg, shift_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    rw_reg, rw_next;
    // Second half of an ACK slot (ack driven, or master ACK already seen).
    logic                    phase_reg, phase_next;
    logic                    ack_n_reg, ack_n_next;
    logic                    sda_in_reg, sda_in_next;
    logic                    wr_done_reg, wr_done_next;
    logic                    rd_done_reg, rd_done_next;
    logic                    scl_q, sda_q;

    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic rise, fall, start_cond, stop_cond, addr_ok;

    assign rise       = !scl_q && SCL;
    assign fall       = scl_q && !SCL;
    assign start_cond = SCL && scl_q && sda_q && !SDA_OUT;
    assign stop_cond  = SCL && scl_q && !sda_q && SDA_OUT;
    assign addr_ok    = (32'(addr_reg) < DEPTH_U);

`ifdef I2C_SLAVE_AUTO_INC_EN
    logic [ADDR_WIDTH-1:0] addr_inc;
    assign addr_inc = (32'(addr_reg) == DEPTH_U - 32'd1) ? '0 : addr_reg + ADDR_WIDTH'(1);
`endif

    // Memory: write commits on the last data rise; the read port is
    // registered and continuously follows addr_reg, so the word is ready well
    // before the SCL fall that loads it into the shift register.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_reg] <= mem_wdata;
        end
        rd_data_reg <= mem[addr_reg];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            addr_reg    <= '0;
            rw_reg      <= 1'b0;
            phase_reg   <= 1'b0;
            ack_n_reg   <= 1'b1;
            sda_in_reg  <= 1'b1;
            wr_done_reg <= 1'b0;
            rd_done_reg <= 1'b0;
            // Idle bus level, so no edge is seen right after reset.
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            addr_reg    <= addr_next;
            rw_reg      <= rw_next;
            phase_reg   <= phase_next;
            ack_n_reg   <= ack_n_next;
            sda_in_reg  <= sda_in_next;
            wr_done_reg <= wr_done_next;
            rd_done_reg <= rd_done_next;
            scl_q       <= SCL;
            sda_q       <= SDA_OUT;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        addr_next    = addr_reg;
        rw_next      = rw_reg;
        phase_next   = phase_reg;
        ack_n_next   = ack_n_reg;
        sda_in_next  = sda_in_reg;
        wr_done_next = 1'b0;
        rd_done_next = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = {shift_reg[DATA_WIDTH-2:0], SDA_OUT};

        if (start_cond) begin
            // START (also repeated START) wins over any bit activity.
            state_next  = S_ADDR;
            cnt_next    = '0;
            phase_next  = 1'b0;
            ack_n_next  = 1'b1;
            sda_in_next = 1'b1;
        end else if (stop_cond) begin
            // Partial frames are simply dropped.
            state_next  = S_IDLE;
            cnt_next    = '0;
            phase_next  = 1'b0;
            ack_n_next  = 1'b1;
            sda_in_next = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                end

                S_ADDR: begin
                    if (rise) begin
                        shift_next = {shift_reg[SH_W-2:0], SDA_OUT};
                        if (cnt_reg == ADDR_LAST) begin
                            // Previous bits hold the address; this bit is R/W.
                            addr_next  = shift_reg[ADDR_WIDTH-1:0];
                            rw_next    = SDA_OUT;
                            cnt_next   = '0;
                            phase_next = 1'b0;
                            state_next = S_ADDR_ACK;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (fall) begin
                        if (!phase_reg) begin
                            if (addr_ok) begin
                                ack_n_next = 1'b0;
                                phase_next = 1'b1;
                            end else begin
                                state_next = S_WAIT_STOP;
                            end
                        end else begin
                            ack_n_next = 1'b1;
                            phase_next = 1'b0;
                            if (rw_reg) begin
                                state_next = S_WR_DATA;
                            end else begin
                                state_next  = S_RD_DATA;
                                sda_in_next = rd_data_reg[DATA_WIDTH-1];
                                shift_next  = SH_W'({rd_data_reg[DATA_WIDTH-2:0], 1'b1});
                            end
                        end
                    end
                end

                S_WR_DATA: begin
                    if (rise) begin
                        shift_next = {shift_reg[SH_W-2:0], SDA_OUT};
                        if (cnt_reg == DATA_LAST) begin
                            mem_we       = 1'b1;
                            wr_done_next = 1'b1;
                            cnt_next     = '0;
                            phase_next   = 1'b0;
                            state_next   = S_WR_ACK;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end

                S_WR_ACK: begin
                    if (fall) begin
                        if (!phase_reg) begin
                            ack_n_next = 1'b0;
                            phase_next = 1'b1;
                        end else begin
                            ack_n_next = 1'b1;
                            phase_next = 1'b0;
`ifdef I2C_SLAVE_AUTO_INC_EN
                            addr_next  = addr_inc;
                            state_next = S_WR_DATA;
`else
                            state_next = S_WAIT_STOP;
`endif
                        end
                    end
                end

                S_RD_DATA: begin
                    if (fall) begin
                        if (cnt_reg == DATA_LAST) begin
                            sda_in_next  = 1'b1;
                            rd_done_next = 1'b1;
                            cnt_next     = '0;
                            phase_next   = 1'b0;
                            state_next   = S_RD_ACK;
                        end else begin
                            sda_in_next = shift_reg[DATA_WIDTH-1];
                            shift_next  = {shift_reg[SH_W-2:0], 1'b1};
                            cnt_next    = cnt_reg + CNT_W'(1);
                        end
                    end
                end

                S_RD_ACK: begin
`ifdef I2C_SLAVE_AUTO_INC_EN
                    if (!phase_reg && rise) begin
                        if (SDA_OUT) begin
                            state_next = S_WAIT_STOP;
                        end else begin
                            // Master ACK: advance now so the registered read
                            // port settles before the reload on the next fall.
                            addr_next  = addr_inc;
                            phase_next = 1'b1;
                        end
                    end else if (phase_reg && fall) begin
                        phase_next  = 1'b0;
                        state_next  = S_RD_DATA;
                        sda_in_next = rd_data_reg[DATA_WIDTH-1];
                        shift_next  = SH_W'({rd_data_reg[DATA_WIDTH-2:0], 1'b1});
                    end
`else
                    if (rise) begin
                        state_next = S_WAIT_STOP;
                    end
`endif
                end

                S_WAIT_STOP: begin
                    ack_n_next  = 1'b1;
                    sda_in_next = 1'b1;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign SDA_IN  = sda_in_reg;
    assign ack_n   = ack_n_reg;
    assign busy    = (state_reg != S_IDLE);
    assign wr_done = wr_done_reg;
    assign rd_done = rd_done_reg;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_mem_slave
//
// Drives I2C transactions onto two targets sharing the bus: "dut" (128 words)
// is scoreboarded, "dut_small" (100 words) is used for the out-of-range case.
// Stimulus pushes expected events (ACK slot, write commit, read byte) into a
// queue; a monitor pops and compares whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_i2c_mem_slave;

    localparam int Q = 4;   // clk cycles per quarter SCL period

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic scl     = 1'b1;
    logic sda     = 1'b1;

    logic a_sda_in, a_ack_n, a_busy, a_wr_done, a_rd_done;
    logic b_sda_in, b_ack_n, b_busy, b_wr_done, b_rd_done;

    always #5 clk = ~clk;

    i2c_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .MEM_DEPTH(128)) dut (
        .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA_OUT(sda),
        .SDA_IN(a_sda_in), .ack_n(a_ack_n), .busy(a_busy),
        .wr_done(a_wr_done), .rd_done(a_rd_done)
    );

    i2c_mem_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .MEM_DEPTH(100)) dut_small (
        .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA_OUT(sda),
        .SDA_IN(b_sda_in), .ack_n(b_ack_n), .busy(b_busy),
        .wr_done(b_wr_done), .rd_done(b_rd_done)
    );

    typedef enum int {EV_ACK, EV_WR, EV_RD} ev_t;
    typedef struct {
        ev_t        kind;
        logic [7:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   b_ack_cnt = 0;
    int   b_wr_cnt  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic void push(ev_t kind, logic [7:0] value);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_check(ev_t kind, logic [7:0] value, string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got event value %0h, required no event", name, value);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value !== value) begin
                errors++;
                $display("FAIL %s: got kind %0d value %0h, required kind %0d value %0h",
                         name, kind, value, e.kind, e.value);
            end
        end
    endfunction

    // Monitor for the scoreboarded target.
    initial begin
        logic       scl_prev = 1'b1;
        logic       ack_prev = 1'b1;
        int         ack_rises = 0;
        logic [7:0] rd_sh = '0;
        forever begin
            @(negedge clk);
            if (!a_ack_n && ack_prev) ack_rises = 0;
            if (scl && !scl_prev) begin
                rd_sh = {rd_sh[6:0], a_sda_in};
                if (!a_ack_n) ack_rises++;
            end
            // On release, ack must have been seen low across exactly one SCL high.
            if (a_ack_n && !ack_prev) pop_check(EV_ACK, 8'(ack_rises), "ack_slot");
            if (a_wr_done) pop_check(EV_WR, 8'h00, "wr_done");
            if (a_rd_done) begin
                pop_check(EV_RD, rd_sh, "rd_byte");
                check("sda_released_after_read", 32'(a_sda_in), 32'd1);
            end
            scl_prev = scl;
            ack_prev = a_ack_n;
        end
    end

    // Activity counters for the small target.
    initial begin
        forever begin
            @(negedge clk);
            if (b_ack_n === 1'b0) b_ack_cnt++;
            if (b_wr_done === 1'b1) b_wr_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        sda = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b0; tick(Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic bus_bit(logic b);
        sda = b;    tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic bus_byte(logic [7:0] v);
        for (int i = 7; i >= 0; i--) bus_bit(v[i]);
    endtask

    task automatic bus_stop();
        sda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        sda = 1'b1; tick(Q);
    endtask

    task automatic end_txn(string what);
        bus_stop();
        tick(4);
        check({what, "_events_pending"}, 32'(exp_q.size()), 32'd0);
        check({what, "_busy_after_stop"}, 32'(a_busy), 32'd0);
        exp_q.delete();
        $display("txn %s done", what);
    endtask

    task automatic do_write(logic [6:0] a, logic [7:0] d, string what);
        push(EV_ACK, 8'd1);
        push(EV_WR, 8'h00);
        push(EV_ACK, 8'd1);
        bus_start();
        check({what, "_busy_after_start"}, 32'(a_busy), 32'd1);
        bus_byte({a, 1'b1});
        bus_bit(1'b1);
        bus_byte(d);
        bus_bit(1'b1);
        end_txn(what);
    endtask

    task automatic do_read(logic [6:0] a, logic [7:0] d, string what);
        push(EV_ACK, 8'd1);
        push(EV_RD, d);
        bus_start();
        bus_byte({a, 1'b0});
        bus_bit(1'b1);
        bus_byte(8'hFF);
        bus_bit(1'b1);      // NACK
        end_txn(what);
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset_ack_n", 32'(a_ack_n), 32'd1);
        check("reset_sda_in", 32'(a_sda_in), 32'd1);
        check("reset_busy", 32'(a_busy), 32'd0);
        check("reset_wr_done", 32'(a_wr_done), 32'd0);
        check("reset_rd_done", 32'(a_rd_done), 32'd0);
        reset_n = 1'b1;
        tick(4);

        // Basic write / read-back
        do_write(7'h03, 8'h02, "write_03_02");
        do_read(7'h03, 8'h02, "read_03_02");
        do_write(7'h03, 8'hA5, "write_03_A5");
        do_read(7'h03, 8'hA5, "read_03_A5");

        // Out of range for the 100-word target, in range for the 128-word one
        b_ack_cnt = 0;
        b_wr_cnt  = 0;
        do_write(7'h70, 8'h66, "write_70_oor");
        check("small_ack_cycles", 32'(b_ack_cnt), 32'd0);
        check("small_wr_done_pulses", 32'(b_wr_cnt), 32'd0);
        check("small_busy_after_stop", 32'(b_busy), 32'd0);
        do_read(7'h70, 8'h66, "read_70");

        // Abort by STOP after 4 data bits
        do_write(7'h10, 8'h5A, "write_10_5A");
        push(EV_ACK, 8'd1);
        bus_start();
        bus_byte({7'h10, 1'b1});
        bus_bit(1'b1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1);
        end_txn("abort_stop_10");
        do_read(7'h10, 8'h5A, "read_10_after_abort");

        // Abort by repeated START, then a new address phase (read)
        push(EV_ACK, 8'd1);
        push(EV_ACK, 8'd1);
        push(EV_RD, 8'h5A);
        bus_start();
        bus_byte({7'h10, 1'b1});
        bus_bit(1'b1);
        for (int i = 0; i < 4; i++) bus_bit(1'b1);
        bus_start();
        bus_byte({7'h10, 1'b0});
        bus_bit(1'b1);
        bus_byte(8'hFF);
        bus_bit(1'b1);
        end_txn("abort_rstart_10");

        // Reset during the 5th address bit
        bus_start();
        for (int i = 0; i < 4; i++) bus_bit(1'b0);
        sda = 1'b0; tick(Q);
        scl = 1'b1; tick(Q);
        check("busy_before_reset", 32'(a_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_ack_n", 32'(a_ack_n), 32'd1);
        check("midreset_sda_in", 32'(a_sda_in), 32'd1);
        check("midreset_busy", 32'(a_busy), 32'd0);
        sda = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(4);
        $display("txn reset_mid_address done");
        do_write(7'h05, 8'h3C, "write_05_after_reset");
        do_read(7'h05, 8'h3C, "read_05_after_reset");

        // Burst write at the top address
        do_write(7'h00, 8'h33, "write_00_33");
        push(EV_ACK, 8'd1);
        push(EV_WR, 8'h00);
        push(EV_ACK, 8'd1);
`ifdef I2C_SLAVE_AUTO_INC_EN
        push(EV_WR, 8'h00);
        push(EV_ACK, 8'd1);
`endif
        bus_start();
        bus_byte({7'h7F, 1'b1});
        bus_bit(1'b1);
        bus_byte(8'h11);
        bus_bit(1'b1);
        bus_byte(8'h22);
        bus_bit(1'b1);
        end_txn("burst_7F");
        do_read(7'h7F, 8'h11, "read_7F");
`ifdef I2C_SLAVE_AUTO_INC_EN
        do_read(7'h00, 8'h22, "read_00_wrapped");
`else
        do_read(7'h00, 8'h33, "read_00_untouched");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
